// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and helpers for the data-memory arbiter slice.
//   size_t          : access size encoding used by both requesters
//   MEM_TOP_DEFAULT : highest valid byte address of the data RAM
//   size_bytes()    : number of bytes touched by an access of a given size
// -----------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_t;

  localparam logic [31:0] MEM_TOP_DEFAULT = 32'h0001_FFFF;

  // Illegal size is reported as 4 bytes; it is flagged as an error anyway,
  // so the value only has to keep the bounds arithmetic well defined.
  function automatic logic [2:0] size_bytes(input size_t sz);
    logic [2:0] n;
    case (sz)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// -----------------------------------------------------------------------------
// dmem_rr_arb
// Two-way round-robin arbiter with a bounded burst lock for requester 1.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   req[1:0]   : request per requester
//   lock[1:0]  : burst lock, only bit 1 is honoured
//   gnt[1:0]   : one-hot (or zero) combinational grant, forced to zero in reset
// -----------------------------------------------------------------------------
module dmem_rr_arb
  import dmem_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  logic             last_owner_r;
  logic             locked_r;
  logic [CNT_W-1:0] burst_cnt_r;
  logic [1:0]       gnt_s;
  logic             unused_lock_s;

  assign unused_lock_s = lock[0];

  // Grant selection: single requester wins, ties go round-robin unless
  // requester 1 holds a lock, which is broken once the burst budget is spent.
  always_comb begin
    gnt_s = 2'b00;
    if (rst) begin
      gnt_s = 2'b00;
    end else begin
      case (req)
        2'b01: gnt_s = 2'b01;
        2'b10: gnt_s = 2'b10;
        2'b11: begin
          if (locked_r && lock[1]) begin
            if (burst_cnt_r < MAX_CNT) begin
              gnt_s = 2'b10;
            end else begin
              gnt_s = 2'b01;
            end
          end else if (last_owner_r) begin
            gnt_s = 2'b01;
          end else begin
            gnt_s = 2'b10;
          end
        end
        default: gnt_s = 2'b00;
      endcase
    end
  end

  assign gnt = gnt_s;

  // Arbitration state: last owner, lock flag and burst counter. The counter
  // only advances while requester 0 is actually waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner_r <= 1'b1;
      locked_r     <= 1'b0;
      burst_cnt_r  <= {CNT_W{1'b0}};
    end else if (gnt_s[1]) begin
      last_owner_r <= 1'b1;
      if (lock[1]) begin
        locked_r <= 1'b1;
        if (req[0] && (burst_cnt_r < MAX_CNT)) begin
          burst_cnt_r <= burst_cnt_r + CNT_W'(1);
        end else begin
          burst_cnt_r <= burst_cnt_r;
        end
      end else begin
        locked_r    <= 1'b0;
        burst_cnt_r <= {CNT_W{1'b0}};
      end
    end else if (gnt_s[0]) begin
      last_owner_r <= 1'b0;
      locked_r     <= 1'b0;
      burst_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      last_owner_r <= last_owner_r;
      locked_r     <= 1'b0;
      burst_cnt_r  <= {CNT_W{1'b0}};
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one byte-addressable data RAM port between the CPU load/store unit
// (requester 0) and the DMA/loader (requester 1).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   req_i/lock_i/we_i : per-requester request, burst lock (bit 1 only), store
//   size_i/addr_i/wdata_i : per-requester access size, byte address, store data
//   gnt_o             : combinational one-hot grant; access happens that cycle
//   rvalid_o/rdata_o  : registered load response, one cycle after the grant
//   err_o             : grant-cycle pulse for illegal size or out-of-range access
//   ram_a/ram_wd/ram_sw/ram_sh/ram_sb : RAM address, write data, store strobes
//   ram_rd            : combinational RAM read data
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int                        ADDRESS_LENGTH = 32,
  parameter logic [ADDRESS_LENGTH-1:0] MEM_TOP        = ADDRESS_LENGTH'(MEM_TOP_DEFAULT),
  parameter int                        MAX_BURST      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0]                     req_i,
  input  logic [1:0]                     lock_i,
  input  logic [1:0]                     we_i,
  input  logic [1:0][1:0]                size_i,
  input  logic [1:0][ADDRESS_LENGTH-1:0] addr_i,
  input  logic [1:0][ADDRESS_LENGTH-1:0] wdata_i,
  output logic [1:0]                     gnt_o,
  output logic [1:0]                     rvalid_o,
  output logic [ADDRESS_LENGTH-1:0]      rdata_o,
  output logic [1:0]                     err_o,
  output logic [ADDRESS_LENGTH-1:0]      ram_a,
  output logic [ADDRESS_LENGTH-1:0]      ram_wd,
  output logic                           ram_sw,
  output logic                           ram_sh,
  output logic                           ram_sb,
  input  logic [ADDRESS_LENGTH-1:0]      ram_rd
);

  localparam int AW1 = ADDRESS_LENGTH + 1;

  logic [1:0]                gnt_s;
  logic                      any_s;
  logic                      we_s;
  size_t                     size_s;
  logic [ADDRESS_LENGTH-1:0] addr_s;
  logic [ADDRESS_LENGTH-1:0] wdata_s;
  logic [AW1-1:0]            last_byte_s;
  logic                      err_s;
  logic                      store_ok_s;
  logic [1:0]                rvalid_r;
  logic [ADDRESS_LENGTH-1:0] rdata_r;

  dmem_rr_arb #(
    .MAX_BURST (MAX_BURST)
  ) u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (req_i),
    .lock (lock_i),
    .gnt  (gnt_s)
  );

  assign any_s = |gnt_s;

  // Winner operand mux; requester 0 fields are used when nobody is granted,
  // which is harmless because every consumer is qualified by any_s.
  always_comb begin
    if (gnt_s[1]) begin
      we_s    = we_i[1];
      size_s  = size_t'(size_i[1]);
      addr_s  = addr_i[1];
      wdata_s = wdata_i[1];
    end else begin
      we_s    = we_i[0];
      size_s  = size_t'(size_i[0]);
      addr_s  = addr_i[0];
      wdata_s = wdata_i[0];
    end
  end

  // Bounds check in one extra bit so an access wrapping past the top of the
  // address space is seen as out of range rather than as a small address.
  assign last_byte_s = {1'b0, addr_s} + AW1'(size_bytes(size_s)) - AW1'(1);
  assign err_s       = any_s && ((size_s == SZ_ILL) || (last_byte_s > {1'b0, MEM_TOP}));
  assign store_ok_s  = any_s && we_s && !err_s;
  assign err_o       = gnt_s & {2{err_s}};
  assign gnt_o       = gnt_s;

  // RAM address/data: winner's operands during a grant, zero when idle.
  always_comb begin
    if (any_s) begin
      ram_a  = addr_s;
      ram_wd = wdata_s;
    end else begin
      ram_a  = {ADDRESS_LENGTH{1'b0}};
      ram_wd = {ADDRESS_LENGTH{1'b0}};
    end
  end

  // Store strobes: exactly one for a legal store, none otherwise.
  always_comb begin
    ram_sw = 1'b0;
    ram_sh = 1'b0;
    ram_sb = 1'b0;
    case (size_s)
      SZ_BYTE: ram_sb = store_ok_s;
      SZ_HALF: ram_sh = store_ok_s;
      SZ_WORD: ram_sw = store_ok_s;
      default: begin
        ram_sw = 1'b0;
        ram_sh = 1'b0;
        ram_sb = 1'b0;
      end
    endcase
  end

  // Load response register: capture RAM data (or zero on error) at the end
  // of a load's grant cycle; rdata holds between loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_r <= 2'b00;
      rdata_r  <= {ADDRESS_LENGTH{1'b0}};
    end else if (any_s && !we_s) begin
      rvalid_r <= gnt_s;
      rdata_r  <= err_s ? {ADDRESS_LENGTH{1'b0}} : ram_rd;
    end else begin
      rvalid_r <= 2'b00;
      rdata_r  <= rdata_r;
    end
  end

  // A response still pending when reset arrives is dropped immediately.
  assign rvalid_o = rvalid_r & {2{~rst}};
  assign rdata_o  = rdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed self-checking bench for dmem_arbiter with a small byte RAM model
// (4 KiB window, indexed by the low 12 address bits).
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic             clk;
  logic             rst;
  logic [1:0]       req_i;
  logic [1:0]       lock_i;
  logic [1:0]       we_i;
  logic [1:0][1:0]  size_i;
  logic [1:0][31:0] addr_i;
  logic [1:0][31:0] wdata_i;
  logic [1:0]       gnt_o;
  logic [1:0]       rvalid_o;
  logic [31:0]      rdata_o;
  logic [1:0]       err_o;
  logic [31:0]      ram_a;
  logic [31:0]      ram_wd;
  logic             ram_sw;
  logic             ram_sh;
  logic             ram_sb;
  logic [31:0]      ram_rd;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:4095];
  logic [11:0] mi;

  dmem_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_i),
    .lock_i   (lock_i),
    .we_i     (we_i),
    .size_i   (size_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .gnt_o    (gnt_o),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .ram_a    (ram_a),
    .ram_wd   (ram_wd),
    .ram_sw   (ram_sw),
    .ram_sh   (ram_sh),
    .ram_sb   (ram_sb),
    .ram_rd   (ram_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: combinational little-endian read, store on strobe at posedge.
  assign mi     = ram_a[11:0];
  assign ram_rd = {mem[mi + 12'd3], mem[mi + 12'd2], mem[mi + 12'd1], mem[mi]};

  // RAM model write port; cleared while reset is held.
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4096; k++) mem[k] <= 8'h00;
    end else if (ram_sw) begin
      mem[mi]         <= ram_wd[7:0];
      mem[mi + 12'd1] <= ram_wd[15:8];
      mem[mi + 12'd2] <= ram_wd[23:16];
      mem[mi + 12'd3] <= ram_wd[31:24];
    end else if (ram_sh) begin
      mem[mi]         <= ram_wd[7:0];
      mem[mi + 12'd1] <= ram_wd[15:8];
    end else if (ram_sb) begin
      mem[mi] <= ram_wd[7:0];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs n cycles with the current inputs; seq[2*i +: 2] is the grant
  // expected in cycle i, and optionally the rvalid expected the cycle after.
  task automatic run_gnt(input string tag, input int n, input logic [31:0] seq, input bit chk_rv);
    for (int i = 0; i < n; i++) begin
      #1;
      check(tag, {30'd0, gnt_o}, {30'd0, seq[2*i +: 2]});
      tick();
      if (chk_rv) check({tag, "_rv"}, {30'd0, rvalid_o}, {30'd0, seq[2*i +: 2]});
    end
  endtask

  initial begin
    rst     = 1'b1;
    req_i   = 2'b00;
    lock_i  = 2'b00;
    we_i    = 2'b00;
    size_i  = '{2'b00, 2'b00};
    addr_i  = '{32'h0, 32'h0};
    wdata_i = '{32'h0, 32'h0};
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", {30'd0, gnt_o}, 32'd0);
    check("rst_rvalid", {30'd0, rvalid_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_err", {30'd0, err_o}, 32'd0);
    check("rst_ram_a", ram_a, 32'd0);
    check("rst_strobes", {29'd0, ram_sw, ram_sh, ram_sb}, 32'd0);
    rst = 1'b0;

    // Requester 0 word store then load of the same address
    req_i = 2'b01; we_i[0] = 1'b1; size_i[0] = 2'b10;
    addr_i[0] = 32'h0001_0000; wdata_i[0] = 32'hDEAD_BEEF;
    #1;
    check("st_gnt", {30'd0, gnt_o}, 32'h1);
    check("st_strobes", {29'd0, ram_sw, ram_sh, ram_sb}, 32'h4);
    check("st_ram_a", ram_a, 32'h0001_0000);
    check("st_ram_wd", ram_wd, 32'hDEAD_BEEF);
    check("st_err", {30'd0, err_o}, 32'd0);
    tick();
    we_i[0] = 1'b0;
    #1;
    check("ld_gnt", {30'd0, gnt_o}, 32'h1);
    check("ld_strobes", {29'd0, ram_sw, ram_sh, ram_sb}, 32'd0);
    tick();
    check("ld_rvalid", {30'd0, rvalid_o}, 32'h1);
    check("ld_rdata", rdata_o, 32'hDEAD_BEEF);
    req_i = 2'b00;
    #1;
    check("idle_gnt", {30'd0, gnt_o}, 32'd0);
    check("idle_ram_a", ram_a, 32'd0);
    tick();
    check("idle_rvalid", {30'd0, rvalid_o}, 32'd0);
    check("idle_rdata_hold", rdata_o, 32'hDEAD_BEEF);

    // Requester 1 alone, making it last owner so the next tie goes to 0
    req_i = 2'b10; we_i[1] = 1'b0; size_i[1] = 2'b10; addr_i[1] = 32'h0001_0000;
    #1;
    check("r1_gnt", {30'd0, gnt_o}, 32'h2);
    tick();
    check("r1_rvalid", {30'd0, rvalid_o}, 32'h2);
    check("r1_rdata", rdata_o, 32'hDEAD_BEEF);

    // Both loading, no lock: strict alternation starting with requester 0
    req_i = 2'b11; addr_i[1] = 32'h0001_0004;
    run_gnt("rr", 4, 32'h0000_0099, 1'b1);

    // Lock held by requester 1 with requester 0 waiting: forced yield after 4
    lock_i = 2'b10;
    run_gnt("burst", 7, 32'h0000_26A9, 1'b1);
    // Requester 0 idle: requester 1 keeps the grant, counter holds at 1
    req_i = 2'b10;
    run_gnt("hold", 9, 32'hAAAA_AAAA, 1'b0);
    // Requester 0 returns: three more locked grants, then the yield
    req_i = 2'b11;
    run_gnt("resume", 4, 32'h0000_006A, 1'b0);
    req_i = 2'b00; lock_i = 2'b00;
    tick();

    // Boundary accesses from requester 1
    req_i = 2'b10; we_i[1] = 1'b1; size_i[1] = 2'b00;
    addr_i[1] = 32'h0001_FFFF; wdata_i[1] = 32'h1234_56AB;
    #1;
    check("sb_top_gnt", {30'd0, gnt_o}, 32'h2);
    check("sb_top_strobes", {29'd0, ram_sw, ram_sh, ram_sb}, 32'h1);
    check("sb_top_err", {30'd0, err_o}, 32'd0);
    check("sb_top_ram_a", ram_a, 32'h0001_FFFF);
    check("sb_top_ram_wd", ram_wd, 32'h1234_56AB);
    tick();
    size_i[1] = 2'b01; wdata_i[1] = 32'h0000_CDEF;
    #1;
    check("sh_top_err", {30'd0, err_o}, 32'h2);
    check("sh_top_strobes", {29'd0, ram_sw, ram_sh, ram_sb}, 32'd0);
    tick();
    check("sh_top_rvalid", {30'd0, rvalid_o}, 32'd0);
    we_i[1] = 1'b0; size_i[1] = 2'b00;
    #1;
    check("lb_top_err", {30'd0, err_o}, 32'd0);
    tick();
    check("lb_top_rvalid", {30'd0, rvalid_o}, 32'h2);
    check("lb_top_byte", rdata_o & 32'h0000_00FF, 32'h0000_00AB);
    size_i[1] = 2'b10; addr_i[1] = 32'h0001_FFFD;
    #1;
    check("lw_over_err", {30'd0, err_o}, 32'h2);
    tick();
    check("lw_over_rvalid", {30'd0, rvalid_o}, 32'h2);
    check("lw_over_rdata", rdata_o, 32'd0);
    addr_i[1] = 32'h0001_FFFC;
    #1;
    check("lw_edge_err", {30'd0, err_o}, 32'd0);
    tick();
    check("lw_edge_rdata", rdata_o, 32'hAB00_0000);
    addr_i[1] = 32'hFFFF_FFFE;
    #1;
    check("lw_wrap_err", {30'd0, err_o}, 32'h2);
    check("lw_wrap_strobes", {29'd0, ram_sw, ram_sh, ram_sb}, 32'd0);
    tick();
    check("lw_wrap_rvalid", {30'd0, rvalid_o}, 32'h2);
    check("lw_wrap_rdata", rdata_o, 32'd0);
    req_i = 2'b00;
    tick();

    // Illegal size store from requester 0 leaves memory untouched
    req_i = 2'b01; we_i[0] = 1'b1; size_i[0] = 2'b11;
    addr_i[0] = 32'h0001_0000; wdata_i[0] = 32'h1111_1111;
    #1;
    check("ill_gnt", {30'd0, gnt_o}, 32'h1);
    check("ill_err", {30'd0, err_o}, 32'h1);
    check("ill_strobes", {29'd0, ram_sw, ram_sh, ram_sb}, 32'd0);
    tick();
    we_i[0] = 1'b0; size_i[0] = 2'b10;
    tick();
    check("ill_after_rvalid", {30'd0, rvalid_o}, 32'h1);
    check("ill_after_rdata", rdata_o, 32'hDEAD_BEEF);

    // Reset in the cycle after a granted load
    tick();
    rst = 1'b1; we_i[0] = 1'b1;
    #1;
    check("rstop_rvalid", {30'd0, rvalid_o}, 32'd0);
    check("rstop_gnt", {30'd0, gnt_o}, 32'd0);
    check("rstop_strobes", {29'd0, ram_sw, ram_sh, ram_sb}, 32'd0);
    tick();
    rst = 1'b0; req_i = 2'b00; we_i = 2'b00;
    #1;
    check("rstop_rdata", rdata_o, 32'd0);
    req_i = 2'b11; addr_i[0] = 32'h0001_0000; addr_i[1] = 32'h0001_0004;
    run_gnt("post_rst", 1, 32'h0000_0001, 1'b1);
    lock_i = 2'b10;
    run_gnt("post_burst", 5, 32'h0000_01AA, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
